// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared states, index field position and peripheral map for the AHB-to-APB bridge
package apb_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ACCESS,
        DONE,
        ERR1,
        ERR2
    } state_t;

    localparam int PSEL_IDX_LSB = 12;
    localparam int IDX_WIDTH    = 4;

    localparam logic [IDX_WIDTH-1:0] UART0     = 4'd0;
    localparam logic [IDX_WIDTH-1:0] TIMER     = 4'd1;
    localparam logic [IDX_WIDTH-1:0] WDOG      = 4'd2;
    localparam logic [IDX_WIDTH-1:0] DUALTIMER = 4'd3;
    localparam logic [IDX_WIDTH-1:0] UART1     = 4'd4;
    localparam logic [IDX_WIDTH-1:0] SPI       = 4'd5;

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - peripheral index to one-hot PSEL plus unmapped flag
module apb_addr_decoder
    import apb_bridge_pkg::*;
#(
    parameter int NUM_SLAVES = 6
) (
    input  logic [IDX_WIDTH-1:0]  i_idx,
    output logic [NUM_SLAVES-1:0] o_psel,
    output logic                  o_unmapped
);

    always_comb begin
        o_psel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (i_idx == IDX_WIDTH'(i)) begin
                o_psel[i] = 1'b1;
            end
        end
        o_unmapped = (int'(i_idx) >= NUM_SLAVES);
    end

endmodule

// File: rtl/apb_bridge_sequencer.sv
// rtl/apb_bridge_sequencer.sv - AHB-Lite slave to APB master bridge, one APB transfer in flight
module apb_bridge_sequencer
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_SLAVES = 6
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    input  logic                  PREADY,
    input  logic [31:0]           PRDATA,
    input  logic                  PSLVERR
);

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:2]   r_paddr;
    logic                    r_pwrite;
    logic [IDX_WIDTH-1:0]    r_idx;
    logic [31:0]             r_pwdata;
    logic [31:0]             r_hrdata;

    logic                    w_valid;
    logic                    w_accept;
    logic                    w_apb_active;
    logic                    w_unmapped;
    logic [NUM_SLAVES-1:0]   w_psel_dec;
    logic                    w_unused;

    assign w_valid  = HSEL & HREADY & HTRANS[1];
    assign w_unused = ^{HTRANS[0], HADDR[1:0]};

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES)
    ) u_addr_decoder (
        .i_idx      (r_idx),
        .o_psel     (w_psel_dec),
        .o_unmapped (w_unmapped)
    );

    // New transfers are only taken in states where HREADYOUT is high.
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_apb_active = 1'b0;
        HREADYOUT    = 1'b1;
        HRESP        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_accept = 1'b1;
                    w_next   = WDATA;
                end
            end
            WDATA: begin
                HREADYOUT = 1'b0;
                w_next    = w_unmapped ? ERR1 : SETUP;
            end
            SETUP: begin
                HREADYOUT    = 1'b0;
                w_apb_active = 1'b1;
                w_next       = ACCESS;
            end
            ACCESS: begin
                HREADYOUT    = 1'b0;
                w_apb_active = 1'b1;
                if (PREADY) begin
                    w_next = PSLVERR ? ERR1 : DONE;
                end
            end
            DONE: begin
                w_accept = w_valid;
                w_next   = w_valid ? WDATA : IDLE;
            end
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                w_next    = ERR2;
            end
            ERR2: begin
                HRESP    = 1'b1;
                w_accept = w_valid;
                w_next   = w_valid ? WDATA : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state  <= IDLE;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_idx    <= '0;
            r_pwdata <= '0;
            r_hrdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_paddr  <= HADDR[ADDR_WIDTH-1:2];
                r_pwrite <= HWRITE;
                r_idx    <= HADDR[PSEL_IDX_LSB +: IDX_WIDTH];
            end
            if (r_state == WDATA && r_pwrite) begin
                r_pwdata <= HWDATA;
            end
            if (r_state == ACCESS && PREADY && !r_pwrite) begin
                r_hrdata <= PRDATA;
            end
        end
    end

    assign PADDR   = {r_paddr, 2'b00};
    assign PSEL    = w_apb_active ? w_psel_dec : '0;
    assign PENABLE = (r_state == ACCESS);
    assign PWRITE  = r_pwrite;
    assign PWDATA  = r_pwdata;
    assign HRDATA  = r_hrdata;

endmodule
